// File: rtl/wb_ahb_master_bridge_pkg.sv
// wb_ahb_pkg: AHB encodings and bridge state type shared by the bridge files
package wb_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;
endpackage

// File: rtl/wb_ahb_master_bridge_if.sv
// wb_ahb_master_bridge_if: Wishbone-classic slave side and AHB master side of the bridge
interface wb_ahb_master_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SEL_W = DW / 8
);
  logic [AW-1:0] wb_adr_i;
  logic [SEL_W-1:0] wb_sel_i;
  logic wb_we_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic wb_cyc_i;
  logic wb_stb_i;
  logic wb_ack_o;
  logic wb_err_o;
  logic [AW-1:0] haddr;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic [2:0] hsize;
  logic hwrite;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic hready;
  logic [1:0] hresp;
  modport master (
    input wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i, hrdata, hready, hresp,
    output wb_dat_o, wb_ack_o, wb_err_o, haddr, htrans, hburst, hsize, hwrite, hwdata
  );
  modport slave (
    output wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i, hrdata, hready, hresp,
    input wb_dat_o, wb_ack_o, wb_err_o, haddr, htrans, hburst, hsize, hwrite, hwdata
  );
endinterface

// File: rtl/wb_ahb_master_bridge_sel_decode.sv
// wb_sel_decode: maps Wishbone byte selects to {legal, hsize, lane offset}
module wb_sel_decode
  import wb_ahb_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] sel,
  output logic legal,
  output logic [2:0] hsize,
  output logic [$clog2(SEL_W)-1:0] off
);
  localparam int OW = $clog2(SEL_W);
  always_comb begin
    legal = 1'b0;
    hsize = HSIZE_BYTE;
    off = '0;
    for (int i = 0; i < SEL_W; i++)
      if (sel == SEL_W'(1) << i) begin
        legal = 1'b1;
        hsize = HSIZE_BYTE;
        off = OW'(i);
      end
    for (int i = 0; i < SEL_W; i += 2)
      if (sel == SEL_W'(3) << i) begin
        legal = 1'b1;
        hsize = HSIZE_HALF;
        off = OW'(i);
      end
    for (int i = 0; i < SEL_W; i += 4)
      if (sel == SEL_W'(15) << i) begin
        legal = 1'b1;
        hsize = HSIZE_WORD;
        off = OW'(i);
      end
    if (SEL_W == 8 && sel == '1) begin
      legal = 1'b1;
      hsize = HSIZE_DWORD;
      off = '0;
    end
  end
endmodule

// File: rtl/wb_ahb_master_bridge.sv
// wb_ahb_master_bridge: Wishbone-classic slave to AHB single-transfer master with retry and abort handling
module wb_ahb_master_bridge
  import wb_ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_RETRY = 4
) (
  input logic hclk,
  input logic hresetn,
  wb_ahb_master_bridge_if.master bus
);
  localparam int SEL_W = DW / 8;
  localparam int OW = $clog2(SEL_W);
  state_t state, state_n;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [2:0] hsize_q, dec_size;
  logic [OW-1:0] off_q, dec_off;
  logic [3:0] retry_q, retry_n;
  logic we_q, dec_legal, err_q, err_n, abort_q, abort_n, start;
  wb_sel_decode #(.SEL_W(SEL_W)) u_sel_decode (
    .sel(bus.wb_sel_i),
    .legal(dec_legal),
    .hsize(dec_size),
    .off(dec_off)
  );
  assign start = state == ST_IDLE && bus.wb_cyc_i && bus.wb_stb_i;
  assign bus.htrans = state == ST_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
  // low address bits come only from the decoded lane, never from wb_adr_i
  assign bus.haddr = (adr_q & ~AW'(SEL_W - 1)) | AW'(off_q);
  assign bus.hsize = hsize_q;
  assign bus.hwrite = we_q;
  assign bus.hburst = HBURST_SINGLE;
  always_comb begin
    state_n = state;
    err_n = err_q;
    abort_n = abort_q;
    retry_n = retry_q;
    case (state)
      ST_IDLE: if (start) begin
        state_n = dec_legal ? ST_ADDR : ST_RESP;
        err_n = !dec_legal;
      end
      ST_ADDR: begin
        abort_n = abort_q | !bus.wb_cyc_i;
        state_n = bus.hready ? ST_DATA : ST_ADDR;
      end
      ST_DATA: begin
        abort_n = abort_q | !bus.wb_cyc_i;
        if (bus.hready) begin
          if (bus.hresp == HRESP_OKAY) state_n = ST_RESP;
          else if (bus.hresp == HRESP_ERROR || retry_q >= 4'(MAX_RETRY)) begin
            state_n = ST_RESP;
            err_n = 1'b1;
          end else begin
            state_n = ST_ADDR;
            retry_n = retry_q + 4'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        err_n = 1'b0;
        abort_n = 1'b0;
        retry_n = '0;
      end
    endcase
  end
  // ack/err are registered on entry to RESP so they are high exactly while in RESP
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
      abort_q <= 1'b0;
      retry_q <= '0;
      adr_q <= '0;
      we_q <= 1'b0;
      dat_q <= '0;
      hsize_q <= HSIZE_BYTE;
      off_q <= '0;
      bus.hwdata <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_err_o <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      abort_q <= abort_n;
      retry_q <= retry_n;
      bus.wb_ack_o <= state_n == ST_RESP && !err_n && !abort_n;
      bus.wb_err_o <= state_n == ST_RESP && err_n && !abort_n;
      if (start) begin
        adr_q <= bus.wb_adr_i;
        we_q <= bus.wb_we_i;
        dat_q <= bus.wb_dat_i;
        hsize_q <= dec_size;
        off_q <= dec_off;
      end
      if (state == ST_ADDR && bus.hready && we_q) bus.hwdata <= dat_q;
      if (state == ST_DATA && bus.hready && bus.hresp == HRESP_OKAY && !we_q) bus.wb_dat_o <= bus.hrdata;
    end
endmodule

// File: doc/wb_ahb_master_bridge.md
Name: wb_ahb_master_bridge

Overview:
Parametrised Wishbone-classic slave to AHB master bridge; the next-generation bus front end for the a23 core on the SoC AHB fabric.
- Registered address and data phases.
- Configurable data width (32/64).
- Byte-lane to HADDR/HSIZE translation, with illegal byte-select rejection.
- Full 2-bit HRESP handling: ERROR maps to wb_err; RETRY/SPLIT re-issue the transfer up to a bounded count.
- Abort-safe handling when wb_cyc drops mid-transfer.

Parameters:
AW, 32, address width (haddr, wb_adr_i).
DW, 32, data width; legal values 32 or 64.
SEL_W, DW/8, byte-select width (derived; not to be overridden).
MAX_RETRY, 4, RETRY/SPLIT re-issues allowed before reporting wb_err (1..15).

Ports:
hclk  in  1  clock for bridge and AHB.
hresetn  in  1  reset, asynchronous, active-low.
wb_adr_i  in  AW  WB byte address; low log2(SEL_W) bits ignored.
wb_sel_i  in  SEL_W  WB byte selects.
wb_we_i  in  1  WB write enable.
wb_dat_i  in  DW  WB write data.
wb_dat_o  out  DW  WB read data, registered.
wb_cyc_i  in  1  WB cycle.
wb_stb_i  in  1  WB strobe.
wb_ack_o  out  1  WB ack, registered, 1-cycle pulse.
wb_err_o  out  1  WB error, registered, 1-cycle pulse.
haddr  out  AW  AHB address.
htrans  out  2  AHB transfer type: IDLE 00 / NONSEQ 10 only.
hburst  out  3  Constant 3'b000 (SINGLE).
hsize  out  3  AHB size.
hwrite  out  1  AHB write.
hwdata  out  DW  AHB write data, registered.
hrdata  in  DW  AHB read data.
hready  in  1  AHB ready.
hresp  in  2  AHB response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, the retry count is 0 and the abort flag is clear.
- Clock and reset: one clock, hclk. hresetn is an asynchronous, active-low reset.
- Mid-transfer reset: reset returns the bridge to IDLE immediately and drops htrans to IDLE. No ack or err is issued.

State machine: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Stays here until wb_cyc_i & wb_stb_i.
  - Captures address, sel, we and write data, and decodes sel.
  - Legal sel: goes to ADDR.
  - Illegal sel: goes to RESP with the error flag set, with no AHB access.
- ADDR:
  - Drives htrans=NONSEQ, haddr, hsize and hwrite from the captured values.
  - On hready=1: loads hwdata with the captured write data (writes only) and goes to DATA.
  - Otherwise holds all address-phase outputs stable.
- DATA:
  - Drives htrans=IDLE; hwdata is held.
  - hready=1 & OKAY: captures hrdata into wb_dat_o (reads only) and goes to RESP (ok).
  - hready=0 & resp≠OKAY (first cycle of a two-cycle response): waits; htrans stays IDLE.
  - hready=1 & ERROR: goes to RESP (err).
  - hready=1 & RETRY/SPLIT with retry count < MAX_RETRY: increments the count and goes back to ADDR, re-issuing an identical transfer.
  - hready=1 & RETRY/SPLIT with retry count = MAX_RETRY: goes to RESP (err).
- RESP:
  - Pulses wb_ack_o or wb_err_o for exactly one cycle, unless the abort flag is set.
  - Clears the retry count and abort flag, then goes to IDLE.
  - Because ack is registered, the master drops stb before IDLE samples it again, so there is no double issue.

Byte-lane translation (sel decode):
- Single bit set at lane k: hsize=000, haddr low bits=k.
- Aligned pair at lanes {2j, 2j+1}: hsize=001, low bits=2j.
- Aligned quad: hsize=010, low bits=0 or 4.
- All ones with DW=64: hsize=011.
- Anything else, including all-zero: illegal.
- Upper haddr bits come from wb_adr_i.

Abort and timing:
- Abort: if wb_cyc_i falls while in ADDR or DATA, the abort flag is set. The AHB transfer still completes per protocol, but RESP emits no ack or err.
- hwrite is held for the whole transfer, including re-issues.
- Zero-wait latency: stb seen at cycle 0, NONSEQ at cycle 1, data phase at cycle 2, ack at cycle 3.

Decomposition:
- Package wb_ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR/RETRY/SPLIT;
  - HSIZE_BYTE/HALF/WORD/DWORD and HBURST_SINGLE;
  - state encoding constants.
- One combinational sub-module, wb_sel_decode (parameter SEL_W): maps sel to {legal, hsize, lane offset}.

Test Plan:
- Word write, addr 0x1000, sel 1111, data 0xDEADBEEF, hready always 1 -> NONSEQ at 0x1000, hsize 010, hwrite=1; hwdata=0xDEADBEEF in data phase; wb_ack 3 cycles after stb.
- Byte read, addr 0x2000, sel 0100, slave returns 0x00AB0000 after 2 wait states -> haddr 0x2002, hsize 000; haddr/htrans stable during the waits; wb_dat_o=0x00AB0000 with ack.
- Two-cycle ERROR response (hready 0/ERROR, then 1/ERROR) -> htrans IDLE during the response; wb_err pulses once; no ack.
- RETRY twice then OKAY -> three NONSEQ issues at the same address; single ack.
- MAX_RETRY+1 RETRYs -> MAX_RETRY+1 issues, then wb_err.
- sel 0110 -> wb_err with htrans never NONSEQ.
- wb_cyc dropped during a wait-stated DATA -> transfer completes on AHB; neither ack nor err asserted.
